// File: rtl/ssd_scan_driver.sv
// Seven-segment scan driver: converts a 13-bit binary value to 4-digit BCD
// with a sequential double-dabble engine. It then time-multiplexes the digits
// onto a common-anode display. Anodes and segments are active low.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value_i,
  input  logic        blank_lz_i,
  output logic [15:0] bcd_o,
  output logic        bcd_valid_o,
  output logic [3:0]  anode_o,
  output logic [6:0]  seg_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]       SHIFT_END = 4'd12;
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [6:0]       SEG_ZERO  = 7'b1000000;

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added, so
  // that the following left shift carries correctly into the next decade.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low glyphs {g,f,e,d,c,b,a}; codes above 9 never occur but stay dark.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  state_t      state_q, state_d;
  logic [28:0] shreg_q, shreg_d;
  logic [3:0]  shcnt_q, shcnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [3:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;

  logic [28:0] shreg_adj;
  logic        cnt_tick;
  logic [3:0]  sel_nib;
  logic        sel_lead_zero;

  // State and datapath registers; reset forces a clean IDLE and digit 0 at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      shcnt_q     <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      cnt_q       <= '0;
      digit_q     <= '0;
      anode_q     <= 4'b1110;
      seg_q       <= SEG_ZERO;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      shcnt_q     <= shcnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
    end
  end

  // Conversion FSM: sample in IDLE, 13 adjust-and-shift steps, then publish.
  // value_i is only looked at in IDLE, so a conversion in flight is coherent.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    shcnt_d     = shcnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    shreg_adj   = {dabble_adjust(shreg_q[28:13]), shreg_q[12:0]};
    case (state_q)
      ST_IDLE: begin
        shreg_d = {16'b0, value_i};
        shcnt_d = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d = shreg_adj << 1;
        shcnt_d = shcnt_q + 4'd1;
        if (shcnt_q == SHIFT_END) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // bcd_o and its valid pulse update together on the edge leaving DONE.
        bcd_d       = shreg_q[28:13];
        bcd_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Refresh divider: the wrap cycle of the counter advances the digit index.
  always_comb begin
    cnt_tick = (cnt_q == CNT_LAST);
    cnt_d    = cnt_tick ? '0 : cnt_q + 1'b1;
    digit_d  = cnt_tick ? digit_q + 2'd1 : digit_q;
  end

  // Digit select: pick the nibble and decide whether it is a leading zero,
  // i.e. it and every more significant nibble are zero. Digit 0 never blanks.
  always_comb begin
    sel_nib       = bcd_q[3:0];
    sel_lead_zero = 1'b0;
    case (digit_q)
      2'd0: begin
        sel_nib       = bcd_q[3:0];
        sel_lead_zero = 1'b0;
      end
      2'd1: begin
        sel_nib       = bcd_q[7:4];
        sel_lead_zero = (bcd_q[15:4] == 12'd0);
      end
      2'd2: begin
        sel_nib       = bcd_q[11:8];
        sel_lead_zero = (bcd_q[15:8] == 8'd0);
      end
      default: begin
        sel_nib       = bcd_q[15:12];
        sel_lead_zero = (bcd_q[15:12] == 4'd0);
      end
    endcase
  end

  // Display outputs, recomputed every cycle so index, value and blanking
  // changes all land one cycle later on the same edge.
  always_comb begin
    anode_d = ~(4'b0001 << digit_q);
    if (blank_lz_i && sel_lead_zero) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_glyph(sel_nib);
    end
  end

  assign bcd_o       = bcd_q;
  assign bcd_valid_o = bcd_valid_q;
  assign anode_o     = anode_q;
  assign seg_o       = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver with a small refresh divider.
module tb_ssd_scan_driver;

  localparam int R = 4;

  logic        clk;
  logic        rst;
  logic [12:0] value_i;
  logic        blank_lz_i;
  logic [15:0] bcd_o;
  logic        bcd_valid_o;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;

  ssd_scan_driver #(.REFRESH_DIV(R), .CNT_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value_i),
    .blank_lz_i (blank_lz_i),
    .bcd_o      (bcd_o),
    .bcd_valid_o(bcd_valid_o),
    .anode_o    (anode_o),
    .seg_o      (seg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int e;
  } item_t;

  item_t sbq[$];
  item_t dq[$];

  int total = 0;
  int bad   = 0;

  int edge_n   = 0;
  int disp_val = 0;
  bit vld_exp  = 1'b0;
  logic [3:0] exp_an = 4'b1110;
  logic [6:0] exp_sg = 7'b1000000;

  logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};
  int p10 [0:3] = '{1, 10, 100, 1000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int d, input bit blank);
    if (blank && d > 0 && (v / p10[d]) == 0) return 7'b1111111;
    return glyph[(v / p10[d]) % 10];
  endfunction

  // Reference model: a conversion samples value_i every 15th edge after reset
  // release and shows up 14 edges later; digit d is lit for R edges each.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbq.delete();
      dq.delete();
      edge_n   = 0;
      disp_val = 0;
      vld_exp  = 1'b0;
    end else begin
      exp_an = ~(4'b0001 << ((edge_n / R) % 4));
      exp_sg = seg_of(disp_val, (edge_n / R) % 4, blank_lz_i);
      if (edge_n % 15 == 0) begin
        sbq.push_back('{int'(value_i), edge_n + 14});
        dq.push_back('{int'(value_i), edge_n + 14});
      end
      vld_exp = 1'b0;
      if (dq.size() > 0 && dq[0].e == edge_n) begin
        disp_val = dq[0].v;
        vld_exp  = 1'b1;
        void'(dq.pop_front());
      end
      edge_n++;
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each valid pulse.
  always @(negedge clk) begin
    item_t it;
    if (rst || edge_n == 0) begin
      chk("rst_anode", anode_o, 4'b1110);
      chk("rst_seg", seg_o, 7'b1000000);
      chk("rst_bcd", bcd_o, 16'h0000);
      chk("rst_valid", bcd_valid_o, 1'b0);
    end else begin
      chk("anode", anode_o, exp_an);
      chk("seg", seg_o, exp_sg);
      chk("bcd_hold", bcd_o, to_bcd(disp_val));
      chk("valid", bcd_valid_o, vld_exp);
      if (bcd_valid_o && sbq.size() > 0) begin
        it = sbq.pop_front();
        chk("conv_value", bcd_o, to_bcd(it.v));
        chk("conv_latency", edge_n - 1, it.e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int guard;
    rst        = 1'b1;
    value_i    = '0;
    blank_lz_i = 1'b0;
    step(2);
    rst = 1'b0;

    value_i = 13'd1234; step(45);
    value_i = 13'd0;    step(30);
    value_i = 13'd8191; step(30);
    value_i = 13'd999;  step(30);
    value_i = 13'd1000; step(30);

    value_i = 13'd7; blank_lz_i = 1'b1; step(40);
    blank_lz_i = 1'b0; step(20);

    // Change the value while a conversion of 42 is shifting.
    value_i = 13'd42; step(16);
    guard = 0;
    while (edge_n % 15 != 3 && guard < 40) begin
      step(1);
      guard++;
    end
    value_i = 13'd1234; step(40);

    // Reset during the 7th shift cycle while digit 2 is lit.
    value_i = 13'd5678;
    guard = 0;
    while (!(edge_n % 15 == 7 && (edge_n % 16) >= 9 && (edge_n % 16) <= 11) && guard < 300) begin
      step(1);
      guard++;
    end
    chk("mid_digit2_anode", anode_o, 4'b1011);
    rst = 1'b1;
    #1;
    chk("async_bcd", bcd_o, 16'h0000);
    chk("async_anode", anode_o, 4'b1110);
    chk("async_seg", seg_o, 7'b1000000);
    chk("async_valid", bcd_valid_o, 1'b0);
    step(3);
    rst = 1'b0;
    step(40);

    repeat (40) begin
      value_i    = 13'($urandom_range(0, 8191));
      blank_lz_i = 1'($urandom_range(0, 1));
      step($urandom_range(1, 40));
    end
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
